// File: rtl/led_sequencer.sv
// led_sequencer: drives six active-low LEDs from one of four pattern engines.
// A prescaler sets the pace. A synchronised, debounced push button steps the
// display mode COUNT -> SCAN -> BLINK -> FILL -> COUNT.
//
// Ports:
//   clk     board clock, all logic on the rising edge
//   rst_n   asynchronous active-low reset (async assert, sync release upstream)
//   btn_n   mode button, active-low, asynchronous to clk
//   bright  4-bit brightness (only with PWM_DIM_EN defined)
//   led     LED drive, active-low (0 = lit)
//   mode    current mode: 0 COUNT, 1 SCAN, 2 BLINK, 3 FILL
//   tick    high for the one cycle on which the pattern advances
//
// Optional build macro: PWM_DIM_EN adds the bright input and a 16-step PWM
// dimmer on the LED drive. Pattern and tick timing do not change.
module led_sequencer #(
  parameter int unsigned TICK_DIV        = 13500000,
  parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_n,
`ifdef PWM_DIM_EN
  input  logic [3:0] bright,
`endif
  output logic [5:0] led,
  output logic [1:0] mode,
  output logic       tick
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [PW-1:0] TickLast = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DbLast   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StCount, StScan, StBlink, StFill} mode_e;

  logic          sync1_q, sync2_q;
  logic          db_level_q, db_level_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          press;

  mode_e         mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    pattern_q, pattern_d;
  logic [2:0]    pos_q, pos_d;
  logic          dir_up_q, dir_up_d;
  logic [2:0]    level_q, level_d;
  logic [6:0]    fill;

  // Debounce: accept a new level only after it has differed from the current
  // one for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    db_cnt_d   = db_cnt_q;
    db_level_d = db_level_q;
    if (sync2_q == db_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DbLast) begin
      db_level_d = sync2_q;
      db_cnt_d   = '0;
    end else begin
      db_cnt_d = db_cnt_q + DW'(1);
    end
  end

  // Press event on the edge where the debounced level falls 1 -> 0.
  assign press = db_level_q & ~db_level_d;

  assign tick = (presc_q == TickLast);

  always_comb begin
    mode_d    = mode_q;
    presc_d   = presc_q;
    pattern_d = pattern_q;
    pos_d     = pos_q;
    dir_up_d  = dir_up_q;
    level_d   = level_q;
    fill      = '0;
    if (press) begin
      // A press wins over a coincident tick and restarts the pattern engine.
      mode_d    = mode_e'(mode_q + 2'd1);
      presc_d   = '0;
      pos_d     = '0;
      dir_up_d  = 1'b1;
      level_d   = '0;
      pattern_d = (mode_d == StScan) ? 6'b000001 : 6'b000000;
    end else if (tick) begin
      presc_d = '0;
      unique case (mode_q)
        StCount: pattern_d = pattern_q + 6'd1;
        StScan: begin
          pos_d = dir_up_q ? pos_q + 3'd1 : pos_q - 3'd1;
          // Turn around at either end so the end positions are not repeated.
          if (pos_d == 3'd5 || pos_d == 3'd0) dir_up_d = ~dir_up_q;
          pattern_d = 6'b000001 << pos_d;
        end
        StBlink: pattern_d = ~pattern_q;
        StFill: begin
          level_d   = (level_q == 3'd6) ? 3'd0 : level_q + 3'd1;
          fill      = (7'd1 << level_d) - 7'd1;
          pattern_d = fill[5:0];
        end
      endcase
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      db_level_q <= 1'b1;
      db_cnt_q   <= '0;
      mode_q     <= StCount;
      presc_q    <= '0;
      pattern_q  <= '0;
      pos_q      <= '0;
      dir_up_q   <= 1'b1;
      level_q    <= '0;
    end else begin
      sync1_q    <= btn_n;
      sync2_q    <= sync1_q;
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      mode_q     <= mode_d;
      presc_q    <= presc_d;
      pattern_q  <= pattern_d;
      pos_q      <= pos_d;
      dir_up_q   <= dir_up_d;
      level_q    <= level_d;
    end
  end

  assign mode = mode_q;

`ifdef PWM_DIM_EN
  logic [3:0] pwm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_q <= '0;
    else        pwm_q <= pwm_q + 4'd1;
  end

  assign led = ~(pattern_q & {6{pwm_q < bright}});
`else
  assign led = ~pattern_q;
`endif

endmodule
